// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Word-addressed data RAM behind a valid/ready request channel; misaligned or out-of-range addresses answer with an error.
// Latency: accept edge to resp_valid is LATENCY+1 cycles; resp_valid is a single-cycle pulse.
// Backpressure: req_ready drops while WAIT counts down; a request offered during RESP is taken back-to-back.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  err_cnt
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          lat_write_q;
    logic [31:0]   lat_addr_q;
    logic [31:0]   lat_wdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          access;
    logic          addr_err;
    logic [AW-1:0] word_idx;

    assign accept   = req_valid && req_ready;
    assign access   = (state_q == S_WAIT) && (cnt_q == '0);
    assign addr_err = (lat_addr_q[1:0] != 2'b00) ||
                      ({2'b00, lat_addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign word_idx = lat_addr_q[AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs come straight from the state register, never from inputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = S_RESP;
            end
            S_RESP: begin
                req_ready  = 1'b1;
                resp_valid = 1'b1;
                state_d    = req_valid ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else if (accept) begin
            cnt_q       <= CNT_INIT;
            lat_write_q <= req_write;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
        end else if (state_q == S_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            err_cnt    <= '0;
        end else if (access) begin
            resp_err   <= addr_err;
            resp_rdata <= (!addr_err && !lat_write_q) ? mem[word_idx] : 32'h0;
            if (addr_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    // RAM is not reset; async reset forces IDLE so an abandoned store never reaches here.
    always_ff @(posedge clk) begin
        if (access && lat_write_q && !addr_err) mem[word_idx] <= lat_wdata_q;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It holds a word-addressed RAM, models a fixed access latency, and flags misaligned or out-of-range addresses with an error response instead of accessing memory. It sits behind the EX/MEM register as the memory side of the load/store interface. It replaces the pipeline's single-cycle data memory when latency has to be modelled.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words in the RAM.
- `LATENCY`, default 2: wait cycles between accept and access. Legal range is at least 1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present. Pulse semantics: a request is consumed on `req_valid && req_ready` and is never re-presented.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  high in IDLE and RESP.
- `busy`  out  1  high in WAIT.
- `resp_valid`  out  1  one-cycle response pulse, high in RESP.
- `resp_rdata`  out  32  load data. It is 0 for stores and for errors.
- `resp_err`  out  1  qualified by `resp_valid`.
- `err_cnt`  out  8  saturating count of error responses.

## Operation
- States: IDLE, WAIT, RESP. Reset state is IDLE.
- **Accept** (IDLE or RESP with `req_valid`):
  - Latch `req_write`, `req_addr` and `req_wdata`.
  - Load counter with `LATENCY-1`.
  - Go to WAIT.
- **RESP without request:** go to IDLE.
- **WAIT, counter ≠ 0:** decrement the counter.
- **WAIT, counter = 0:** perform the access on this edge, then go to RESP.
- **Error check:** an address is an error if `addr[1:0] != 0` or `addr[31:2] >= DEPTH_WORDS`.
  - Store, no error: `mem[addr[31:2]] <= wdata`; `resp_rdata` = 0.
  - Load, no error: `resp_rdata` = `mem[addr[31:2]]`.
  - Error: no RAM read or write; `resp_rdata` = 0; `resp_err` = 1; `err_cnt` increments, saturating at 255.
- **Output registers:** `resp_rdata` and `resp_err` are registered at the access edge. They hold until the next access edge or reset. Their value is only meaningful while `resp_valid` is high.
- **Ordering:** requests are strictly serialized, so read-after-write to the same word returns the new data.
- **Ignored requests:** `req_valid` seen in WAIT is ignored. Requesters must wait for `req_ready`.
- **Reset:**
  - Outputs: `req_ready` = 1, `busy` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `err_cnt` = 0.
  - Internal state: state = IDLE, counter = 0, latched request cleared.
  - RAM contents are not reset.

## Timing
- **Latency:** a request accepted at the end of cycle 0 gives `resp_valid` in cycle `LATENCY+1`. With `LATENCY=2`, that is cycle 3. `busy` is high for cycles 1 through `LATENCY`.
- **Back-to-back:** a request presented during a RESP cycle is accepted at that edge. Peak throughput is one request per `LATENCY+1` cycles.
- **Outputs:** `req_ready`, `busy` and `resp_valid` are decoded directly from the state register (glitch-free, no combinational path from inputs). `resp_rdata` and `resp_err` are registered.
- **Reset mid-operation:** `rst_n` low in WAIT abandons the request.
  - A pending store never modifies RAM.
  - No `resp_valid` is produced for the abandoned request.
  - Outputs take their reset values immediately, with no clock needed.
- **Reset release:** on the first edge after `rst_n` rises, the block is in IDLE and can accept a request.
- **`err_cnt` saturation:** at 255, further errors leave it at 255. Error responses are otherwise unaffected.

## Test plan
- **Store then load, `LATENCY=2`:**
  - Store addr 0x10, data 0xDEADBEEF, accepted cycle 0 → `resp_valid` in cycle 3 with `resp_err`=0, `resp_rdata`=0.
  - Load 0x10 in the RESP cycle → `resp_rdata`=0xDEADBEEF in cycle 6.
- **Misaligned store:** store to 0x13 → `resp_err`=1, `err_cnt`=1. A following load of 0x10 still returns the prior value.
- **Out of range:** load `4*DEPTH_WORDS` (0x400 with defaults) → `resp_err`=1, `resp_rdata`=0.
- **Reset mid-WAIT:**
  - Store 0x55 to 0x20, then assert `rst_n` low in cycle 1 → all outputs reset asynchronously, no `resp_valid`.
  - After release, load 0x20 → returns the old contents, not 0x55.
- **Busy ignore and saturation:**
  - `req_valid` asserted during WAIT → ignored, no extra response.
  - 260 misaligned requests → `err_cnt` = 255.
- **`LATENCY=1` back-to-back:** a stream of loads presented on every RESP → `resp_valid` every 2nd cycle, with data matching the preloaded words in order.
